// File: rtl/io_interface_if.sv
// -----------------------------------------------------------------------------
// io_interface_if
// Device-side bundle of the programmed-I/O stage: a valid/ready input channel
// (keyboard -> input FIFO) and a valid/ready output channel (OUTR -> printer).
//
// Signals:
//   dev_in_data   [7:0]  keyboard byte               (device -> stage)
//   dev_in_valid         keyboard byte present       (device -> stage)
//   dev_in_ready         FIFO can accept a byte      (stage  -> device)
//   dev_out_data  [7:0]  OUTR contents               (stage  -> device)
//   dev_out_valid        OUTR byte offered           (stage  -> device)
//   dev_out_ready        printer accepts the byte    (device -> stage)
//
// Modports:
//   master : the device side (keyboard/printer model)
//   slave  : the io_interface block
// -----------------------------------------------------------------------------
interface io_interface_if;
   logic [7:0] dev_in_data;
   logic       dev_in_valid;
   logic       dev_in_ready;
   logic [7:0] dev_out_data;
   logic       dev_out_valid;
   logic       dev_out_ready;

   modport master (
      output dev_in_data,
      output dev_in_valid,
      input  dev_in_ready,
      input  dev_out_data,
      input  dev_out_valid,
      output dev_out_ready
   );

   modport slave (
      input  dev_in_data,
      input  dev_in_valid,
      output dev_in_ready,
      output dev_out_data,
      output dev_out_valid,
      input  dev_out_ready
   );
endinterface : io_interface_if

// File: rtl/io_interface.sv
// -----------------------------------------------------------------------------
// io_interface
// Programmed-I/O stage of the basic computer. Owns the input register INPR
// (head of a small keyboard FIFO), the output register OUTR and the FGI/FGO
// flags consumed by the control unit for SKI/SKO and interrupt entry.
//
// Parameters:
//   IN_DEPTH  input FIFO entries, power of two, 2..16
//   OUT_GAP   idle cycles after an output handshake before FGO reasserts
//
// Ports:
//   CLK        system clock, rising edge
//   rst        asynchronous active-low reset
//   AC_lo      AC[7:0], source for OUT
//   INP        execute strobe: pop FIFO head (control unit loads INPR into AC)
//   OUT        execute strobe: OUTR <- AC_lo, FGO <- 0
//   dev        device-side valid/ready channels (slave modport)
//   INPR       FIFO head, mem[rd_ptr]
//   FGI        input flag, FIFO non-empty
//   FGO        output flag, OUTR free
//   in_level   FIFO occupancy
//   io_err     sticky misuse flag (INP while FGI=0, OUT while FGO=0)
// -----------------------------------------------------------------------------
module io_interface #(
   parameter int IN_DEPTH = 4,
   parameter int OUT_GAP  = 2
) (
   input  logic                        CLK,
   input  logic                        rst,
   input  logic [7:0]                  AC_lo,
   input  logic                        INP,
   input  logic                        OUT,
   io_interface_if.slave               dev,
   output logic [7:0]                  INPR,
   output logic                        FGI,
   output logic                        FGO,
   output logic [$clog2(IN_DEPTH):0]   in_level,
   output logic                        io_err
);

   localparam int PW = $clog2(IN_DEPTH);
   localparam int LW = PW + 1;
   localparam int GW = (OUT_GAP > 1) ? $clog2(OUT_GAP) : 1;

   typedef enum logic [1:0] {
      O_IDLE,
      O_SEND,
      O_GAP
   } o_state_t;

   // ---------------------------------------------------------------------------
   // Input FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]    r_mem [IN_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          r_fgi;

   logic          w_in_ready;
   logic          w_push;
   logic          w_pop;
   logic          w_in_err;
   logic [LW-1:0] w_level_nxt;

   assign w_in_ready = (r_level != LW'(IN_DEPTH));
   assign w_push     = dev.dev_in_valid & w_in_ready;
   // A pop is only legal against the registered flag; INP on an empty FIFO is
   // flagged even when a push lands on the same edge.
   assign w_pop      = INP & r_fgi;
   assign w_in_err   = INP & ~r_fgi;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + LW'(1);
         2'b01:   w_level_nxt = r_level - LW'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         // NOTE: the storage is reset because INPR exposes mem[rd_ptr] directly
         // and must read 0 out of reset; at this depth the cost is trivial.
         for (int i = 0; i < IN_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_fgi    <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= dev.dev_in_data;
            r_wr_ptr        <= r_wr_ptr + PW'(1);   // power-of-two depth wraps
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_level <= w_level_nxt;
         r_fgi   <= (w_level_nxt != '0);
      end
   end

   assign INPR             = r_mem[r_rd_ptr];
   assign FGI              = r_fgi;
   assign in_level         = r_level;
   assign dev.dev_in_ready = w_in_ready;

   // ---------------------------------------------------------------------------
   // Output FSM
   // ---------------------------------------------------------------------------
   o_state_t      r_state;
   o_state_t      w_next_state;
   logic [GW-1:0] r_gap_cnt;
   logic [GW-1:0] w_gap_nxt;
   logic [7:0]    r_outr;
   logic          w_outr_load;
   logic          w_out_err;

   always_comb begin
      w_next_state = r_state;
      w_gap_nxt    = r_gap_cnt;
      w_outr_load  = 1'b0;
      w_out_err    = 1'b0;
      case (r_state)
         O_IDLE: begin
            if (OUT) begin
               w_outr_load  = 1'b1;
               w_next_state = O_SEND;
            end
         end
         O_SEND: begin
            w_out_err = OUT;
            if (dev.dev_out_ready) begin
               if (OUT_GAP == 0) begin
                  w_next_state = O_IDLE;
               end else begin
                  w_next_state = O_GAP;
                  w_gap_nxt    = GW'(OUT_GAP - 1);
               end
            end
         end
         O_GAP: begin
            w_out_err = OUT;
            if (r_gap_cnt == '0) w_next_state = O_IDLE;
            else                 w_gap_nxt    = r_gap_cnt - GW'(1);
         end
         default: w_next_state = O_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_state   <= O_IDLE;
         r_gap_cnt <= '0;
         r_outr    <= '0;
      end else begin
         r_state   <= w_next_state;
         r_gap_cnt <= w_gap_nxt;
         if (w_outr_load) r_outr <= AC_lo;
      end
   end

   // FGO is high exactly in O_IDLE: it drops on the OUT edge and returns on the
   // edge that re-enters O_IDLE, which is the handshake edge when OUT_GAP=0.
   assign FGO               = (r_state == O_IDLE);
   assign dev.dev_out_valid = (r_state == O_SEND);
   assign dev.dev_out_data  = r_outr;

   // ---------------------------------------------------------------------------
   // Sticky misuse flag
   // ---------------------------------------------------------------------------
   logic r_io_err;

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst)                        r_io_err <= 1'b0;
      else if (w_in_err || w_out_err) r_io_err <= 1'b1;
   end

   assign io_err = r_io_err;

endmodule : io_interface

// File: tb/tb_io_interface.sv
// -----------------------------------------------------------------------------
// tb_io_interface
// Directed testbench for io_interface. Instance u_a uses IN_DEPTH=4,
// OUT_GAP=2; instance u_b uses OUT_GAP=0 for the immediate-FGO case.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_io_interface;

   logic CLK = 1'b0;
   logic rst;
   always #5 CLK = ~CLK;

   int tests  = 0;
   int failed = 0;

   // instance A stimulus / observation
   logic [7:0] ac_lo;
   logic       inp;
   logic       out_s;
   logic [7:0] a_inpr;
   logic       a_fgi, a_fgo, a_err;
   logic [2:0] a_level;

   // instance B stimulus / observation
   logic [7:0] b_ac;
   logic       b_out;
   logic [7:0] b_inpr;
   logic       b_fgi, b_fgo, b_err;
   logic [2:0] b_level;

   io_interface_if a_if ();
   io_interface_if b_if ();

   io_interface #(.IN_DEPTH(4), .OUT_GAP(2)) u_a (
      .CLK      (CLK),
      .rst      (rst),
      .AC_lo    (ac_lo),
      .INP      (inp),
      .OUT      (out_s),
      .dev      (a_if.slave),
      .INPR     (a_inpr),
      .FGI      (a_fgi),
      .FGO      (a_fgo),
      .in_level (a_level),
      .io_err   (a_err)
   );

   io_interface #(.IN_DEPTH(4), .OUT_GAP(0)) u_b (
      .CLK      (CLK),
      .rst      (rst),
      .AC_lo    (b_ac),
      .INP      (1'b0),
      .OUT      (b_out),
      .dev      (b_if.slave),
      .INPR     (b_inpr),
      .FGI      (b_fgi),
      .FGO      (b_fgo),
      .in_level (b_level),
      .io_err   (b_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      rst = 1'b1;
   endtask

   logic [7:0] push_bytes [4];

   initial begin
      rst   = 1'b0;
      ac_lo = 8'h00; inp = 1'b0; out_s = 1'b0;
      b_ac  = 8'h00; b_out = 1'b0;
      a_if.dev_in_data = 8'h00; a_if.dev_in_valid = 1'b0; a_if.dev_out_ready = 1'b0;
      b_if.dev_in_data = 8'h00; b_if.dev_in_valid = 1'b0; b_if.dev_out_ready = 1'b0;
      push_bytes[0] = 8'h41; push_bytes[1] = 8'h42;
      push_bytes[2] = 8'h43; push_bytes[3] = 8'h44;

      // ---- reset state ------------------------------------------------------
      #2;
      check("rst_fgo",      a_fgo, 1);
      check("rst_fgi",      a_fgi, 0);
      check("rst_level",    a_level, 0);
      check("rst_inpr",     a_inpr, 8'h00);
      check("rst_in_ready", a_if.dev_in_ready, 1);
      check("rst_valid",    a_if.dev_out_valid, 0);
      check("rst_err",      a_err, 0);
      #1 rst = 1'b1;

      // ---- enter O_SEND with a byte buffered and io_err set, then reset -----
      inp = 1'b1;                                   // FGI=0 -> misuse
      a_if.dev_in_data = 8'hAA; a_if.dev_in_valid = 1'b1;
      ac_lo = 8'h33; out_s = 1'b1;
      tick();
      inp = 1'b0; out_s = 1'b0; a_if.dev_in_valid = 1'b0;
      check("pre_valid", a_if.dev_out_valid, 1);
      check("pre_data",  a_if.dev_out_data, 8'h33);
      check("pre_fgo",   a_fgo, 0);
      check("pre_level", a_level, 1);
      check("pre_fgi",   a_fgi, 1);
      check("pre_inpr",  a_inpr, 8'hAA);
      check("pre_err",   a_err, 1);
      #2 rst = 1'b0;
      #1;                                           // still before next edge
      check("arst_fgo",      a_fgo, 1);
      check("arst_fgi",      a_fgi, 0);
      check("arst_valid",    a_if.dev_out_valid, 0);
      check("arst_level",    a_level, 0);
      check("arst_err",      a_err, 0);
      check("arst_in_ready", a_if.dev_in_ready, 1);
      check("arst_inpr",     a_inpr, 8'h00);
      #1 rst = 1'b1;

      // ---- output path, OUT_GAP=2 -------------------------------------------
      tick();
      ac_lo = 8'h7E; out_s = 1'b1;
      tick();
      out_s = 1'b0;
      check("out_fgo_low", a_fgo, 0);
      for (int i = 0; i < 5; i++) begin
         check("send_valid", a_if.dev_out_valid, 1);
         check("send_data",  a_if.dev_out_data, 8'h7E);
         if (i == 2) begin
            ac_lo = 8'h11; out_s = 1'b1;            // OUT while FGO=0
         end
         tick();
         out_s = 1'b0;
      end
      check("dup_out_err",  a_err, 1);
      a_if.dev_out_ready = 1'b1;
      check("hs_valid", a_if.dev_out_valid, 1);
      check("hs_data",  a_if.dev_out_data, 8'h7E);
      tick();
      a_if.dev_out_ready = 1'b0;
      check("gap1_valid", a_if.dev_out_valid, 0);
      check("gap1_fgo",   a_fgo, 0);
      check("gap1_outr",  a_if.dev_out_data, 8'h7E);
      tick();
      check("gap2_fgo",   a_fgo, 0);
      tick();
      check("idle_fgo",   a_fgo, 1);
      check("idle_valid", a_if.dev_out_valid, 0);

      // ---- output path, OUT_GAP=0 -------------------------------------------
      b_ac = 8'h5A; b_out = 1'b1;
      tick();
      b_out = 1'b0;
      check("b_valid", b_if.dev_out_valid, 1);
      check("b_data",  b_if.dev_out_data, 8'h5A);
      check("b_fgo0",  b_fgo, 0);
      b_if.dev_out_ready = 1'b1;
      tick();
      b_if.dev_out_ready = 1'b0;
      check("b_fgo_imm",   b_fgo, 1);
      check("b_valid_off", b_if.dev_out_valid, 0);

      // ---- fill FIFO, overflow attempt, drain --------------------------------
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a_if.dev_in_data = push_bytes[i]; a_if.dev_in_valid = 1'b1;
         tick();
      end
      check("full_ready", a_if.dev_in_ready, 0);
      check("full_level", a_level, 4);
      check("full_inpr",  a_inpr, 8'h41);
      a_if.dev_in_data = 8'h45;                      // fifth byte, still valid
      tick();
      a_if.dev_in_valid = 1'b0;
      check("ovf_level", a_level, 4);
      check("ovf_inpr",  a_inpr, 8'h41);
      for (int i = 1; i < 4; i++) begin
         inp = 1'b1;
         tick();
         check("pop_inpr",  a_inpr, push_bytes[i]);
         check("pop_level", a_level, 3'(4 - i));
      end
      tick();                                        // fourth pop
      inp = 1'b0;
      check("drain_fgi",   a_fgi, 0);
      check("drain_level", a_level, 0);
      check("drain_err",   a_err, 0);

      // ---- INP on empty FIFO ------------------------------------------------
      inp = 1'b1;
      tick();
      inp = 1'b0;
      check("empty_inp_level", a_level, 0);
      check("empty_inp_err",   a_err, 1);

      // ---- simultaneous push and pop at level 1 ------------------------------
      a_if.dev_in_data = 8'h50; a_if.dev_in_valid = 1'b1;
      tick();
      check("sim_pre_level", a_level, 1);
      a_if.dev_in_data = 8'h55; inp = 1'b1;
      tick();
      a_if.dev_in_valid = 1'b0; inp = 1'b0;
      check("sim_level", a_level, 1);
      check("sim_inpr",  a_inpr, 8'h55);

      // ---- simultaneous push and INP with FIFO empty -------------------------
      do_reset();
      a_if.dev_in_data = 8'h60; a_if.dev_in_valid = 1'b1; inp = 1'b1;
      tick();
      a_if.dev_in_valid = 1'b0; inp = 1'b0;
      check("emp_sim_level", a_level, 1);
      check("emp_sim_inpr",  a_inpr, 8'h60);
      check("emp_sim_err",   a_err, 1);

      // ---- wrap-around: interleaved push/pop ---------------------------------
      do_reset();
      for (int k = 0; k < 10; k++) begin
         a_if.dev_in_data = 8'(k); a_if.dev_in_valid = 1'b1;
         tick();
         a_if.dev_in_valid = 1'b0;
         check("wrap_inpr",  a_inpr, 32'(k));
         check("wrap_level", a_level, 1);
         inp = 1'b1;
         tick();
         inp = 1'b0;
         check("wrap_empty", a_level, 0);
      end
      check("wrap_err", a_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_io_interface
